x1t_mode_video: RTL
===================

// Module: x1t_mode_video
// PURPOSE
//  Video-side consumer of the X1turbo mode latches (ports 1FD0/1FE0).
//  - Takes the CPU-written mode bits, shadows them and commits them only at vertical-blank start,
//    so a frame never changes mode mid-scan.
//  - Applies the 1FE0 black-colour masking to the text/GR0/GR1 pixel layers, then
//    priority-mixes them into one 3-bit digital RGB pixel through a 2-stage pipeline.
// PARAMETERS
//  PIPE_BYPASS  0  1 = stage-2 register bypassed (latency 1); 0 = normal latency 2
// PORTS
//  CLK          in   1  system/video clock
//  I_RESET_N    in   1  asynchronous active-low reset
//  I_MODE_1FD0  in   8  live 1FD0 latch value (CPU side)
//  I_MODE_1FE0  in   7  live 1FE0 latch value [2:0]=black col,[3]=txt,[4]=gr0,[5]=gr1,[6]=blk
//  I_VBLANK     in   1  vertical blank level from CRTC timing
//  I_PIX_EN     in   1  pixel-valid strobe (one per dot clock enable)
//  I_TXT_COL    in   3  text layer colour (0 = transparent)
//  I_GR0_COL    in   3  graphics plane 0 colour
//  I_GR1_COL    in   3  graphics plane 1 colour
//  I_DISP_EN    in   1  active display area (0 = border)
//  O_RGB        out  3  mixed pixel {G,R,B}
//  O_RGB_EN     out  1  O_RGB valid
//  O_MODE_ACT   out  8  committed 1FD0 value (HIRESO,LINE400,TEXT12,... to rest of video)
//  O_PENDING    out  1  live mode differs from committed mode, commit awaiting vblank
//  O_COMMIT     out  1  one-cycle pulse on the cycle the shadow registers update
// BEHAVIOUR
//  Reset (I_RESET_N=0, async): shadow_fd0=8'h00, shadow_fe0=7'h00, O_RGB=0, O_RGB_EN=0,
//   O_PENDING=0, O_COMMIT=0, pipeline valid bits cleared; all flops clear immediately.
//  Commit: vb_d = I_VBLANK registered; vb_rise = I_VBLANK & ~vb_d.
//   - On vb_rise: shadow_fd0<=I_MODE_1FD0, shadow_fe0<=I_MODE_1FE0, O_COMMIT<=1 next cycle.
//   - O_COMMIT pulses on every vb_rise, even if nothing changed.
//   - O_PENDING registered: (I_MODE_1FD0!=shadow_fd0)|(I_MODE_1FE0!=shadow_fe0).
//   - Write landing in the same cycle as vb_rise: that value is the one sampled.
//   - Write one cycle later: waits for the next frame; O_PENDING=1 until then.
//   - I_VBLANK high out of reset: no commit until a fresh 0->1 edge (vb_d resets to 1).
//  Stage 1 (on I_PIX_EN): per layer L in {TXT,GR0,GR1}:
//   - mL = (col_L==shadow_fe0[2:0]) & enable_bit_L & (col_L!=0) ? 3'd0 : col_L.
//   - brd = ~I_DISP_EN & shadow_fe0[6]; s1_valid<=1.
//  Stage 2 (on s1_valid):
//   - brd=1 -> O_RGB=0.
//   - else if ~I_DISP_EN -> O_RGB=0.
//   - else text if mTXT!=0, else GR0 if mGR0!=0, else GR1.
//   - O_RGB_EN<=s1_valid.
//  Latency: I_PIX_EN cycle N -> O_RGB_EN/O_RGB at cycle N+2 (N+1 if PIPE_BYPASS=1).
//  I_PIX_EN=0: pipeline holds data; O_RGB_EN falls to 0 after latency; O_RGB holds last value.
//  Mask uses the committed shadow, never the live latch. A mode change mid-frame affects
//   pixels only after the next vb_rise; pixels already in the pipe complete with the old mask.
//  Back-to-back I_PIX_EN every cycle: full throughput, one pixel per cycle, no stalls.
//  Reset asserted mid-line: in-flight pixels are discarded (no O_RGB_EN after release until new input).
// STRUCTURE
//  Package x1t_video_pkg:
//   - localparams for 1FE0 bit indices (BLK_COL_LSB/MSB, TXT_BLK, GR0_BLK, GR1_BLK, BRD_BLK);
//   - typedef of the 3-bit colour.
//  One sub-module, x1t_black_mask: combinational per-layer mask (col, black_col, enable) -> col,
//   instanced three times.
//  Commit logic, pending compare and pipeline registers stay in the top module.
// TESTING
//  1. Reset release with VBLANK=1; set 1FE0=7'h0A -> no O_COMMIT until VBLANK 0->1.
//     O_PENDING=1 meanwhile.
//  2. 1FE0=7'h0A (black col 2, txt enable); TXT=2, GR0=5 -> O_RGB=5 two cycles after PIX_EN.
//     Same with TXT=3 -> O_RGB=3.
//  3. Write 1FD0=8'h03 one cycle after vb_rise -> O_MODE_ACT stays 0 for the frame.
//     Updates and O_COMMIT pulses at the next vb_rise.
//  4. Back-to-back PIX_EN for 16 cycles with ramping colours -> 16 consecutive O_RGB_EN,
//     values in order, latency 2.
//  5. DISP_EN=0 with 1FE0[6]=1 and GR1=7 -> O_RGB=0. With DISP_EN=1, GR1=7, others 0 -> O_RGB=7.
//  6. Assert I_RESET_N low mid-burst -> O_RGB=0, O_RGB_EN=0 immediately.
//     Shadows read 0, no stale pixel after release.

Source files
------------

// File: rtl/x1t_video_pkg.sv
// Shared 1FE0 bit positions and the 3-bit digital colour type for the X1turbo video mixer.
// Pure definitions: no logic, no timing, no flow control.
package x1t_video_pkg;

  localparam int BLK_COL_LSB = 0;
  localparam int BLK_COL_MSB = 2;
  localparam int TXT_BLK     = 3;
  localparam int GR0_BLK     = 4;
  localparam int GR1_BLK     = 5;
  localparam int BRD_BLK     = 6;

  typedef logic [2:0] col_t;

endpackage

// File: rtl/x1t_black_mask.sv
// Per-layer black-colour mask: a non-zero colour equal to the black colour becomes transparent.
// Combinational, zero latency, no backpressure.
module x1t_black_mask
  import x1t_video_pkg::*;
(
  input  col_t col_i,
  input  col_t black_col_i,
  input  logic enable_i,
  output col_t col_o
);

  always_comb begin
    col_o = col_i;
    if (enable_i && (col_i != 3'd0) && (col_i == black_col_i)) begin
      col_o = 3'd0;
    end
  end

endmodule

// File: rtl/x1t_mode_video.sv
// Shadows 1FD0/1FE0 into the video domain at vblank start, masks and priority-mixes text/GR0/GR1.
// Latency 2 (1 with PIPE_BYPASS); I_PIX_EN is a free-running strobe, no backpressure.
module x1t_mode_video
  import x1t_video_pkg::*;
#(
  parameter bit PIPE_BYPASS = 1'b0
) (
  input  logic       CLK,
  input  logic       I_RESET_N,
  input  logic [7:0] I_MODE_1FD0,
  input  logic [6:0] I_MODE_1FE0,
  input  logic       I_VBLANK,
  input  logic       I_PIX_EN,
  input  col_t       I_TXT_COL,
  input  col_t       I_GR0_COL,
  input  col_t       I_GR1_COL,
  input  logic       I_DISP_EN,
  output col_t       O_RGB,
  output logic       O_RGB_EN,
  output logic [7:0] O_MODE_ACT,
  output logic       O_PENDING,
  output logic       O_COMMIT
);

  logic       vblank_q, vblank_d;
  logic       vb_rise;
  logic [7:0] shadow_fd0_q, shadow_fd0_d;
  logic [6:0] shadow_fe0_q, shadow_fe0_d;
  logic       commit_q, commit_d;
  logic       pending_q, pending_d;

  logic       s1_vld_q, s1_vld_d;
  col_t       s1_txt_q, s1_txt_d;
  col_t       s1_gr0_q, s1_gr0_d;
  col_t       s1_gr1_q, s1_gr1_d;
  logic       s1_brd_q, s1_brd_d;
  logic       s1_disp_q, s1_disp_d;

  col_t       rgb_q, rgb_d;
  logic       rgb_en_q, rgb_en_d;
  col_t       mix;

  col_t       m_txt, m_gr0, m_gr1;
  col_t       black_col;

  // Masking always uses the committed shadow, never the live CPU latch.
  assign black_col = shadow_fe0_q[BLK_COL_MSB:BLK_COL_LSB];

  x1t_black_mask u_mask_txt (
    .col_i       (I_TXT_COL),
    .black_col_i (black_col),
    .enable_i    (shadow_fe0_q[TXT_BLK]),
    .col_o       (m_txt)
  );

  x1t_black_mask u_mask_gr0 (
    .col_i       (I_GR0_COL),
    .black_col_i (black_col),
    .enable_i    (shadow_fe0_q[GR0_BLK]),
    .col_o       (m_gr0)
  );

  x1t_black_mask u_mask_gr1 (
    .col_i       (I_GR1_COL),
    .black_col_i (black_col),
    .enable_i    (shadow_fe0_q[GR1_BLK]),
    .col_o       (m_gr1)
  );

  always_comb begin
    vblank_d     = I_VBLANK;
    vb_rise      = I_VBLANK & ~vblank_q;
    shadow_fd0_d = shadow_fd0_q;
    shadow_fe0_d = shadow_fe0_q;
    commit_d     = vb_rise;
    pending_d    = (I_MODE_1FD0 != shadow_fd0_q) || (I_MODE_1FE0 != shadow_fe0_q);
    if (vb_rise) begin
      shadow_fd0_d = I_MODE_1FD0;
      shadow_fe0_d = I_MODE_1FE0;
    end

    // Stage-1 data holds while the strobe is idle; only the valid bit drops.
    s1_vld_d  = I_PIX_EN;
    s1_txt_d  = s1_txt_q;
    s1_gr0_d  = s1_gr0_q;
    s1_gr1_d  = s1_gr1_q;
    s1_brd_d  = s1_brd_q;
    s1_disp_d = s1_disp_q;
    if (I_PIX_EN) begin
      s1_txt_d  = m_txt;
      s1_gr0_d  = m_gr0;
      s1_gr1_d  = m_gr1;
      s1_brd_d  = ~I_DISP_EN & shadow_fe0_q[BRD_BLK];
      s1_disp_d = I_DISP_EN;
    end

    if (s1_brd_q || !s1_disp_q) begin
      mix = 3'd0;
    end else if (s1_txt_q != 3'd0) begin
      mix = s1_txt_q;
    end else if (s1_gr0_q != 3'd0) begin
      mix = s1_gr0_q;
    end else begin
      mix = s1_gr1_q;
    end

    rgb_d    = s1_vld_q ? mix : rgb_q;
    rgb_en_d = s1_vld_q;
  end

  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      vblank_q     <= 1'b1;
      shadow_fd0_q <= 8'h00;
      shadow_fe0_q <= 7'h00;
      commit_q     <= 1'b0;
      pending_q    <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_txt_q     <= 3'd0;
      s1_gr0_q     <= 3'd0;
      s1_gr1_q     <= 3'd0;
      s1_brd_q     <= 1'b0;
      s1_disp_q    <= 1'b0;
      rgb_q        <= 3'd0;
      rgb_en_q     <= 1'b0;
    end else begin
      vblank_q     <= vblank_d;
      shadow_fd0_q <= shadow_fd0_d;
      shadow_fe0_q <= shadow_fe0_d;
      commit_q     <= commit_d;
      pending_q    <= pending_d;
      s1_vld_q     <= s1_vld_d;
      s1_txt_q     <= s1_txt_d;
      s1_gr0_q     <= s1_gr0_d;
      s1_gr1_q     <= s1_gr1_d;
      s1_brd_q     <= s1_brd_d;
      s1_disp_q    <= s1_disp_d;
      rgb_q        <= rgb_d;
      rgb_en_q     <= rgb_en_d;
    end
  end

  assign O_RGB      = PIPE_BYPASS ? mix : rgb_q;
  assign O_RGB_EN   = PIPE_BYPASS ? s1_vld_q : rgb_en_q;
  assign O_MODE_ACT = shadow_fd0_q;
  assign O_PENDING  = pending_q;
  assign O_COMMIT   = commit_q;

endmodule
